// File: rtl/blob_locator.sv
// Two-stage colour-blob bounding-box locator over a raster stream; reports once per frame.
// Optional macro BLOB_LOCATOR_COUNT_EN adds the pixel_count output.
module blob_locator #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned MIN_COUNT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [7:0]  pixel,
  input  logic [7:0]  color,
  input  logic [7:0]  mask,
  input  logic        enable,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] width,
  output logic [10:0] height,
  output logic        found,
  output logic        valid
`ifdef BLOB_LOCATOR_COUNT_EN
  ,
  output logic [19:0] pixel_count
`endif
);

  localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
  localparam logic [19:0] MIN_C  = 20'(MIN_COUNT);

  // Stage 1
  logic        match_d, match_q;
  logic        last_d, last_q;
  logic [10:0] hc_q, vc_q;
  logic        active;

  // Stage 2 accumulators
  logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [19:0] cnt_q;
  logic [10:0] xmin_m, xmax_m, ymin_m, ymax_m;
  logic [19:0] cnt_m;
  logic        found_m;

  // Output registers
  logic [10:0] x_d, y_d, w_d, h_d;
  logic [10:0] x_q, y_q, w_q, h_q;
  logic        found_q, valid_q;
  logic [19:0] pcnt_q;

  always_comb begin
    active  = ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);
    match_d = active && enable && ((pixel & mask) == (color & mask));
    last_d  = active && (hcount == H_LAST) && (vcount == V_LAST);
  end

  // Accumulators merged with the pixel currently held in stage 1, so the
  // final pixel of a frame is included in the same edge that latches the report.
  always_comb begin
    xmin_m = xmin_q;
    xmax_m = xmax_q;
    ymin_m = ymin_q;
    ymax_m = ymax_q;
    cnt_m  = cnt_q;
    if (match_q) begin
      if (hc_q < xmin_q) xmin_m = hc_q;
      if (hc_q > xmax_q) xmax_m = hc_q;
      if (vc_q < ymin_q) ymin_m = vc_q;
      if (vc_q > ymax_q) ymax_m = vc_q;
      if (cnt_q != '1)   cnt_m  = cnt_q + 20'd1;
    end
    found_m = (cnt_m >= MIN_C);
    x_d = '0;
    y_d = '0;
    w_d = '0;
    h_d = '0;
    if (found_m) begin
      x_d = xmin_m;
      y_d = ymin_m;
      w_d = xmax_m - xmin_m + 11'd1;
      h_d = ymax_m - ymin_m + 11'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      match_q <= 1'b0;
      last_q  <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      xmin_q  <= '1;
      ymin_q  <= '1;
      xmax_q  <= '0;
      ymax_q  <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      match_q <= match_d;
      last_q  <= last_d;
      hc_q    <= hcount;
      vc_q    <= vcount;
      valid_q <= last_q;
      if (last_q) begin
        x_q     <= x_d;
        y_q     <= y_d;
        w_q     <= w_d;
        h_q     <= h_d;
        found_q <= found_m;
        pcnt_q  <= cnt_m;
        xmin_q  <= '1;
        ymin_q  <= '1;
        xmax_q  <= '0;
        ymax_q  <= '0;
        cnt_q   <= '0;
      end else begin
        xmin_q  <= xmin_m;
        ymin_q  <= ymin_m;
        xmax_q  <= xmax_m;
        ymax_q  <= ymax_m;
        cnt_q   <= cnt_m;
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign width  = w_q;
  assign height = h_q;
  assign found  = found_q;
  assign valid  = valid_q;
`ifdef BLOB_LOCATOR_COUNT_EN
  assign pixel_count = pcnt_q;
`else
  logic unused_pcnt;
  assign unused_pcnt = ^pcnt_q;
`endif

endmodule

// File: tb/tb_blob_locator.sv
// Scoreboard bench for blob_locator: two instances (MIN_COUNT 1 and 5) driven by one raster.
// pixel_count is checked only when BLOB_LOCATOR_COUNT_EN is defined.
module tb_blob_locator;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HT = H + 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic [7:0]  pixel = '0;
  logic [7:0]  color = 8'h1C;
  logic [7:0]  mask = 8'hFF;
  logic [10:0] x1, y1, w1, h1, x5, y5, w5, h5;
  logic        f1, v1, f5, v5;
  logic [19:0] c1, c5;

  always #5 clock = ~clock;

  blob_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .pixel(pixel), .color(color), .mask(mask), .enable(enable),
    .x(x1), .y(y1), .width(w1), .height(h1), .found(f1), .valid(v1)
`ifdef BLOB_LOCATOR_COUNT_EN
    , .pixel_count(c1)
`endif
  );

  blob_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .pixel(pixel), .color(color), .mask(mask), .enable(enable),
    .x(x5), .y(y5), .width(w5), .height(h5), .found(f5), .valid(v5)
`ifdef BLOB_LOCATOR_COUNT_EN
    , .pixel_count(c5)
`endif
  );

`ifndef BLOB_LOCATOR_COUNT_EN
  assign c1 = '0;
  assign c5 = '0;
`endif

  typedef struct {
    logic [10:0] x, y, w, h;
    logic        f;
    logic [19:0] cnt;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q5[$];
  int   mh[$];
  int   mv[$];
  int   cyc = 0;
  logic rst_s = 1'b0;
  bit   started = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t        e1, e5;
  logic [79:0] hold1 = '0, hold5 = '0, a1, a5;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_s <= reset_n;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [79:0] pack(input exp_t e);
`ifdef BLOB_LOCATOR_COUNT_EN
    return {15'd0, e.x, e.y, e.w, e.h, e.f, e.cnt};
`else
    return {15'd0, e.x, e.y, e.w, e.h, e.f, 20'd0};
`endif
  endfunction

  // Report computed directly from the list of matched coordinates since the last report/reset.
  function automatic exp_t model(input int minc, input int c);
    exp_t e;
    int   xmn, xmx, ymn, ymx;
    e.x = '0; e.y = '0; e.w = '0; e.h = '0; e.f = 1'b0;
    e.cnt = 20'(mh.size());
    e.cyc = c;
    if (mh.size() >= minc && mh.size() > 0) begin
      xmn = 2047; ymn = 2047; xmx = 0; ymx = 0;
      foreach (mh[i]) begin
        if (mh[i] < xmn) xmn = mh[i];
        if (mh[i] > xmx) xmx = mh[i];
        if (mv[i] < ymn) ymn = mv[i];
        if (mv[i] > ymx) ymx = mv[i];
      end
      e.x = 11'(xmn);
      e.y = 11'(ymn);
      e.w = 11'(xmx - xmn + 1);
      e.h = 11'(ymx - ymn + 1);
      e.f = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input int h, input int v, input logic [7:0] p, input bit rn);
    bit act;
    @(posedge clock);
    #1;
    hcount  = 11'(h);
    vcount  = 11'(v);
    pixel   = p;
    reset_n = rn;
    act = (h < H) && (v < V);
    if (!rn) begin
      mh.delete();
      mv.delete();
    end else begin
      if (act && enable && ((p & mask) == (color & mask))) begin
        mh.push_back(h);
        mv.push_back(v);
      end
      if (act && h == H - 1 && v == V - 1) begin
        q1.push_back(model(1, cyc + 2));
        q5.push_back(model(5, cyc + 2));
        mh.delete();
        mv.delete();
      end
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int h, input int v);
    logic [7:0] r, nz;
    r  = 8'($urandom);
    nz = (r == 8'h1C) ? 8'h1D : r;
    case (mode)
      0: return (h >= 3 && h <= 6 && v >= 2 && v <= 4) ? 8'h1C : nz;
      1: return nz;
      2: return r;
      3: return (h == H - 1 && v == V - 1) ? 8'h1C : nz;
      4: return (v == 5 && h >= 2 && h < 6) ? 8'h1C : nz;
      5: return (v == 5 && h >= 2 && h < 7) ? 8'h1C : nz;
      6: return ((v == 1 && h >= 4 && h < 8) || (v == 6 && h >= 9 && h < 12)) ? 8'h1C : nz;
      default: return r & 8'h03;
    endcase
  endfunction

  task automatic frame(input int mode, input int rows = V + 1);
    for (int v = 0; v < rows; v++)
      for (int h = 0; h < HT; h++)
        step(h, v, pix(mode, h, v), !(mode == 6 && v == 3 && (h == 5 || h == 6)));
  endtask

  always @(negedge clock) begin
    if (started) begin
      a1 = {15'd0, x1, y1, w1, h1, f1, c1};
      if (!rst_s) begin
        hold1 = '0;
        chk("dut1 valid in reset", 80'(v1), '0);
        chk("dut1 reset outputs", a1, hold1);
      end else if (v1) begin
        if (q1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut1 unexpected valid: actual 1 required 0");
        end else begin
          e1 = q1.pop_front();
          hold1 = pack(e1);
          chk("dut1 valid cycle", 80'(cyc), 80'(e1.cyc));
          chk("dut1 report", a1, hold1);
        end
      end else begin
        chk("dut1 hold", a1, hold1);
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      a5 = {15'd0, x5, y5, w5, h5, f5, c5};
      if (!rst_s) begin
        hold5 = '0;
        chk("dut5 valid in reset", 80'(v5), '0);
        chk("dut5 reset outputs", a5, hold5);
      end else if (v5) begin
        if (q5.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut5 unexpected valid: actual 1 required 0");
        end else begin
          e5 = q5.pop_front();
          hold5 = pack(e5);
          chk("dut5 valid cycle", 80'(cyc), 80'(e5.cyc));
          chk("dut5 report", a5, hold5);
        end
      end else begin
        chk("dut5 hold", a5, hold5);
      end
    end
  end

  initial begin
    step(0, 0, 8'h00, 1'b0);
    started = 1'b1;
    repeat (2) step(0, 0, 8'h00, 1'b0);
    frame(0);
    frame(0);
    frame(1);
    mask = 8'h00;
    frame(2);
    mask = 8'hFF;
    frame(3);
    frame(4);
    frame(5);
    frame(6);
    enable = 1'b0;
    frame(0);
    enable = 1'b1;
    frame(0, 5);
    frame(3);
    for (int i = 0; i < 4; i++) begin
      color = 8'($urandom_range(0, 3));
      mask  = 8'($urandom);
      frame(7);
    end
    repeat (6) step(0, V + 1, 8'h00, 1'b1);
    chk("dut1 pending reports", 80'(q1.size()), '0);
    chk("dut5 pending reports", 80'(q5.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
